// File: rtl/npu_pkg.sv
// npu_pkg: shared defaults for the MAC-array back end, the partial-sum
// accumulator FSM encoding and the Q31 rounding constant.
package npu_pkg;

    localparam int MAX_GROUPS_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF  = 8;
    localparam int PASS_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } acc_state_t;

    // Half an LSB of a Q31 product; shifted left by the extra right shift
    // so that the final arithmetic shift rounds half up.
    localparam logic signed [63:0] Q31_ROUND = 64'sh0000_0000_4000_0000;

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one group lane of the requantizer. Stage 1 forms the 64-bit
// Q31 product; stage 2 rounds, shifts, adds the zero point and clamps to int8.
module requant_lane
    import npu_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [31:0]          mult,
    input  logic [4:0]           shift,
    input  logic [7:0]           zero_point,
    input  logic [7:0]           act_min,
    input  logic [7:0]           act_max,
    output logic [7:0]           q
);

    logic signed [63:0] acc_x;
    logic signed [63:0] mult_x;
    logic signed [63:0] prod_s1;
    logic [4:0]         shift_s1;
    logic [7:0]         zp_s1;
    logic [7:0]         min_s1;
    logic [7:0]         max_s1;
    logic [5:0]         sh_amt;
    logic signed [63:0] rounded;
    logic signed [63:0] shifted;
    logic signed [63:0] biased;
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    logic [7:0]         q_next;

    assign acc_x  = 64'($signed(acc));
    assign mult_x = 64'($signed(mult));

    // Stage 1: register the product together with the config it must be finished with
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_s1  <= '0;
            shift_s1 <= '0;
            zp_s1    <= '0;
            min_s1   <= '0;
            max_s1   <= '0;
        end else begin
            prod_s1  <= acc_x * mult_x;
            shift_s1 <= shift;
            zp_s1    <= zero_point;
            min_s1   <= act_min;
            max_s1   <= act_max;
        end
    end

    // Stage 2 datapath: round-half-up shift, zero point, clamp (inverted range yields act_max)
    always_comb begin
        sh_amt  = 6'd31 + {1'b0, shift_s1};
        rounded = prod_s1 + (Q31_ROUND <<< shift_s1);
        shifted = rounded >>> sh_amt;
        biased  = shifted + 64'($signed(zp_s1));
        lo      = 64'($signed(min_s1));
        hi      = 64'($signed(max_s1));
        if (lo > hi) begin
            q_next = max_s1;
        end else if (biased < lo) begin
            q_next = min_s1;
        end else if (biased > hi) begin
            q_next = max_s1;
        end else begin
            q_next = biased[7:0];
        end
    end

    // Stage 2 register: the finished int8 for this lane
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/psum_requant.sv
// psum_requant: accumulates cfg_num_passes MAC beats per output tile into
// per-group partial sums, requantizes them to int8 and hands the vector to
// writeback over valid/ready.
// Optional build macro PSUM_SAT_EN: saturating accumulation plus a sticky
// acc_sat output; without it the accumulators wrap.
module psum_requant
    import npu_pkg::*;
#(
    parameter int MAX_GROUPS = MAX_GROUPS_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int PASS_W     = PASS_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PASS_W-1:0]               cfg_num_passes,
    input  logic [31:0]                     cfg_mult,
    input  logic [4:0]                      cfg_shift,
    input  logic [7:0]                      cfg_zero_point,
    input  logic [7:0]                      cfg_act_min,
    input  logic [7:0]                      cfg_act_max,
    input  logic                            valid_in,
    input  logic [3:0]                      num_groups_in,
    input  logic [MAX_GROUPS*ACC_WIDTH-1:0] mac_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_GROUPS*OUT_WIDTH-1:0] out_data,
    output logic [3:0]                      out_num_groups,
    output logic                            busy,
    output logic                            err_overrun,
    output logic                            err_grp_mismatch
`ifdef PSUM_SAT_EN
    ,
    output logic                            acc_sat
`endif
);

    acc_state_t           state;
    logic [ACC_WIDTH-1:0] acc     [MAX_GROUPS];
    logic [ACC_WIDTH-1:0] acc_sum [MAX_GROUPS];
    logic [PASS_W-1:0]    pass_cnt;
    logic [PASS_W-1:0]    n_sh;
    logic [PASS_W-1:0]    n_new;
    logic [3:0]           grp_sh;
    logic [31:0]          mult_sh;
    logic [4:0]           shift_sh;
    logic [7:0]           zp_sh;
    logic [7:0]           min_sh;
    logic [7:0]           max_sh;
    logic                 v1;
    logic                 v2;
    logic [3:0]           cnt_s1;
    logic [3:0]           cnt_s2;
    logic [7:0]           lane_q  [MAX_GROUPS];
`ifdef PSUM_SAT_EN
    logic [ACC_WIDTH:0]   wide_sum [MAX_GROUPS];
    logic                 sat_any;
`endif

    assign n_new = (cfg_num_passes == '0) ? PASS_W'(1) : cfg_num_passes;
    assign busy  = (state != IDLE);

    // Next accumulator value per lane for a non-first beat (wrap or saturate)
    always_comb begin
`ifdef PSUM_SAT_EN
        sat_any = 1'b0;
`endif
        for (int g = 0; g < MAX_GROUPS; g++) begin
`ifdef PSUM_SAT_EN
            wide_sum[g] = {acc[g][ACC_WIDTH-1], acc[g]}
                        + {mac_in[g*ACC_WIDTH + ACC_WIDTH - 1], mac_in[g*ACC_WIDTH +: ACC_WIDTH]};
            if (wide_sum[g][ACC_WIDTH] != wide_sum[g][ACC_WIDTH-1]) begin
                acc_sum[g] = wide_sum[g][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                sat_any    = 1'b1;
            end else begin
                acc_sum[g] = wide_sum[g][ACC_WIDTH-1:0];
            end
`else
            acc_sum[g] = acc[g] + mac_in[g*ACC_WIDTH +: ACC_WIDTH];
`endif
        end
    end

    // Tile FSM: first beat loads sums and shadows config, later beats accumulate, FLUSH hands off
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pass_cnt         <= '0;
            n_sh             <= '0;
            grp_sh           <= '0;
            mult_sh          <= '0;
            shift_sh         <= '0;
            zp_sh            <= '0;
            min_sh           <= '0;
            max_sh           <= '0;
            err_grp_mismatch <= 1'b0;
`ifdef PSUM_SAT_EN
            acc_sat          <= 1'b0;
`endif
            for (int g = 0; g < MAX_GROUPS; g++) begin
                acc[g] <= '0;
            end
        end else begin
            case (state)
                IDLE, FLUSH: begin
                    if (valid_in) begin
                        for (int g = 0; g < MAX_GROUPS; g++) begin
                            acc[g] <= mac_in[g*ACC_WIDTH +: ACC_WIDTH];
                        end
                        grp_sh   <= num_groups_in;
                        pass_cnt <= PASS_W'(1);
                        n_sh     <= n_new;
                        mult_sh  <= cfg_mult;
                        shift_sh <= cfg_shift;
                        zp_sh    <= cfg_zero_point;
                        min_sh   <= cfg_act_min;
                        max_sh   <= cfg_act_max;
                        state    <= (n_new == PASS_W'(1)) ? FLUSH : ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (valid_in) begin
                        for (int g = 0; g < MAX_GROUPS; g++) begin
                            acc[g] <= acc_sum[g];
                        end
                        pass_cnt <= pass_cnt + PASS_W'(1);
                        if (num_groups_in != grp_sh) begin
                            err_grp_mismatch <= 1'b1;
                        end
`ifdef PSUM_SAT_EN
                        if (sat_any) begin
                            acc_sat <= 1'b1;
                        end
`endif
                        if ((pass_cnt + PASS_W'(1)) == n_sh) begin
                            state <= FLUSH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_GROUPS; g++) begin : g_lane
        requant_lane #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .acc        (acc[g]),
            .mult       (mult_sh),
            .shift      (shift_sh),
            .zero_point (zp_sh),
            .act_min    (min_sh),
            .act_max    (max_sh),
            .q          (lane_q[g])
        );
    end

    // Pipeline valid/group-count tracking and the output holding register with handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            v1             <= 1'b0;
            v2             <= 1'b0;
            cnt_s1         <= '0;
            cnt_s2         <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_num_groups <= '0;
            err_overrun    <= 1'b0;
        end else begin
            v1     <= (state == FLUSH);
            cnt_s1 <= grp_sh;
            v2     <= v1;
            cnt_s2 <= cnt_s1;
            if (v2) begin
                if (!out_valid || out_ready) begin
                    out_valid      <= 1'b1;
                    out_num_groups <= cnt_s2;
                    for (int g = 0; g < MAX_GROUPS; g++) begin
                        out_data[g*OUT_WIDTH +: OUT_WIDTH] <=
                            (g < int'(cnt_s2)) ? OUT_WIDTH'(lane_q[g]) : '0;
                    end
                end else begin
                    err_overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/psum_requant.md
Name: psum_requant

Overview:
- Downstream of the grouped MAC array. Consumes per-group 32-bit signed dot-product results, one beat per K-tile.
- Accumulates cfg_num_passes beats per output tile into per-group partial sums.
- Requantizes each sum to int8 (fixed-point multiplier, right shift, zero point, activation clamp).
- Presents the int8 vector to the writeback stage over a valid/ready handshake.

Parameters:
- MAX_GROUPS, 8, number of independent group lanes (matches the MAC array).
- ACC_WIDTH, 32, width of each incoming and accumulated partial sum.
- OUT_WIDTH, 8, width of each requantized output element.
- PASS_W, 8, width of the pass counter and cfg_num_passes.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_num_passes  in  PASS_W  beats per output tile; 0 is treated as 1
- cfg_mult  in  32  signed Q31 requant multiplier, shared by all groups
- cfg_shift  in  5  right shift applied after the Q31 multiply (0..31)
- cfg_zero_point  in  8  signed output zero point
- cfg_act_min  in  8  signed clamp low
- cfg_act_max  in  8  signed clamp high
- valid_in  in  1  MAC result beat valid (no backpressure upstream)
- num_groups_in  in  4  active groups for this beat
- mac_in  in  MAX_GROUPS*ACC_WIDTH  signed per-group results; group g at [g*ACC_WIDTH +: ACC_WIDTH]
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accept
- out_data  out  MAX_GROUPS*OUT_WIDTH  int8 per group; inactive groups are 0
- out_num_groups  out  4  active group count for out_data
- busy  out  1  tile accumulation in progress
- err_overrun  out  1  sticky: finished tile dropped because output was still held
- err_grp_mismatch  out  1  sticky: num_groups_in changed mid-tile

Behaviour:
- Reset: one clock, synchronous, active-high reset `rst`. All outputs, accumulators, counters and the FSM go to 0/IDLE.
- Config inputs are sampled on the first beat of a tile and held in shadow registers until the tile completes.
- Accumulator FSM states:
  - IDLE: on valid_in, load acc[g] = mac_in[g], latch the group count, pass_cnt = 1. If N = 1, go to FLUSH; else go to ACCUM.
  - ACCUM: on valid_in, acc[g] += mac_in[g] and pass_cnt++. When pass_cnt reaches N, go to FLUSH. Cycles without valid_in are ignored (gaps allowed).
  - FLUSH: one cycle. Hands acc to the requant pipeline, returns to IDLE. A valid_in arriving in FLUSH starts the next tile: the IDLE load is applied in the same cycle, so there are no bubbles.
- busy = (state != IDLE).
- If num_groups_in differs from the latched count on a non-first beat: set err_grp_mismatch, keep the latched count, and still accumulate all lanes.
- Requant pipeline, per lane, 2 stages:
  - S1: p = acc * cfg_mult, 64-bit signed.
  - S2: r = (p + (1 << (30+shift))) >>> (31+shift), arithmetic; then r += zero_point; then clamp to [act_min, act_max]; truncate to 8 bits.
  - If act_min > act_max, the output is act_max.
  - Lanes with index >= latched group count produce 0.
- Latency: the output register updates and out_valid rises 2 cycles after FLUSH, i.e. 3 cycles after the final beat's valid_in edge.
- Output handshake:
  - out_valid stays high and out_data/out_num_groups stay stable until out_valid && out_ready.
  - If a new result arrives in the same cycle as the handshake, it is loaded and out_valid stays high.
  - If a new result arrives while out_valid is high and out_ready is low, the new result is dropped, err_overrun is set, and the held data is unchanged.
- Sticky error flags clear only on rst.
- Reset mid-tile discards partial sums and any in-flight pipeline data.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined: accumulation saturates to the signed ACC_WIDTH range; a sticky output acc_sat (1 bit) is added and set on any saturation.
- Undefined: accumulation wraps modulo 2^ACC_WIDTH and the acc_sat port is absent.

Decomposition:
- Shared package npu_pkg holds:
  - the ACC_WIDTH/OUT_WIDTH/MAX_GROUPS defaults;
  - the FSM state encodings IDLE = 0, ACCUM = 1, FLUSH = 2;
  - the Q31 rounding constant.
- One sub-module, requant_lane: a single lane's 2-stage multiply/shift/zero-point/clamp. It is instantiated MAX_GROUPS times under generate.
- The FSM, accumulators and output handshake stay in the top module.

Test Plan:
- N=1, mult=0x40000000, shift=0, zp=0, clamp [-128,127], mac_in g0=100, g1=-7, num_groups=2 -> 3 cycles later out_data g0=50, g1=-3 (rounds -3.5 to -3), g2..7=0, out_num_groups=2.
- N=4, beats g0 = 10, 20, 30, 40 with a 2-cycle gap after beat 2, mult=0x7FFFFFFF, shift=1 -> single out g0=50, out_valid once, busy high from beat 1 until FLUSH.
- Clamp: acc=1000, mult=0x7FFFFFFF, shift=0, zp=5, range [0,127] -> 127; acc=-1000 -> 0.
- Backpressure: out_ready=0 while a second N=1 tile completes -> first result held, err_overrun=1; then out_ready=1 -> the first result is accepted and out_valid drops.
- Back-to-back N=2 tiles with valid_in every cycle, out_ready=1 -> one output every 2 cycles, no drops, no errors.
- Boundary: group count 3 then 5 within an N=2 tile -> err_grp_mismatch=1 and out_num_groups=3. With PSUM_SAT_EN defined, 0x7FFFFFF0 + 0x100 -> acc=0x7FFFFFFF and acc_sat=1.
